// File: rtl/mpu_wb.sv
// ============================================================================
// mpu_wb
// ----------------------------------------------------------------------------
// Writeback stage of the MPU datapath. Lane-positioned ALU results are merged
// into an NREG x 64-bit register file with a read-modify-write that touches
// only the addressed lane. Two registered read ports, each with a bypass from
// a write in the same cycle, feed the ALU. A sequential clear engine zeroes
// the file after reset or on a clear request.
//
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   clr                  one-cycle request to zero the register file
//   busy                 clear engine running
//   wb_valid / wb_ready  writeback handshake
//   wb_addr/size/sel     destination register, lane size, lane index
//   wb_data              result already shifted into lane position
//   r0_addr / r0_data    read port 0 (one-cycle latency)
//   r1_addr / r1_data    read port 1 (one-cycle latency)
//   wr_count             saturating count of accepted writebacks
//
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mpu_wb #(
  parameter int NREG = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [1:0]               wb_size,
  input  logic [2:0]               wb_sel,
  input  logic [63:0]              wb_data,
  input  logic [$clog2(NREG)-1:0]  r0_addr,
  output logic [63:0]              r0_data,
  input  logic [$clog2(NREG)-1:0]  r1_addr,
  output logic [63:0]              r1_data,
  output logic [15:0]              wr_count
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] C_LAST = AW'(NREG - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t         r_state;
  logic [AW-1:0]  r_cnt;
  logic           r_busy;
  logic [15:0]    r_wr_count;
  logic [63:0]    r_regs [NREG];
  logic [63:0]    r_rd0;
  logic [63:0]    r_rd1;

  logic           w_accept;
  logic [11:0]    w_off_full;
  logic [5:0]     w_off;
  logic [63:0]    w_base;
  logic [63:0]    w_lmask;
  logic [63:0]    w_merged;
  logic           w_zero_rd;

  assign busy     = r_busy;
  assign wb_ready = ~r_busy & ~clr;
  assign w_accept = wb_valid & wb_ready;
  assign wr_count = r_wr_count;
  assign r0_data  = r_rd0;
  assign r1_data  = r_rd1;

  // Lane offset is sel * (8 << size) taken modulo 64; a qword lane therefore
  // always lands at offset 0 and a dword with sel 2 wraps back to the bottom.
  always_comb begin
    w_off_full = {6'd0, wb_sel, 3'b000} << wb_size;
    w_off      = w_off_full[5:0];
    case (wb_size)
      2'd0:    w_base = 64'h0000_0000_0000_00ff;
      2'd1:    w_base = 64'h0000_0000_0000_ffff;
      2'd2:    w_base = 64'h0000_0000_ffff_ffff;
      default: w_base = 64'hffff_ffff_ffff_ffff;
    endcase
    w_lmask  = w_base << w_off;
    w_merged = (r_regs[wb_addr] & ~w_lmask) | (wb_data & w_lmask);
  end

  // Reads return zero whenever the file is being (or about to be) cleared;
  // once the engine finishes every entry is zero, so this is also correct
  // for a read issued during the final clear cycle.
  assign w_zero_rd = sys_rst | r_busy | clr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_CLEAR;
      r_busy     <= 1'b1;
      r_cnt      <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state    <= ST_CLEAR;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_wr_count <= '0;
          end else if (w_accept && (r_wr_count != 16'hffff)) begin
            r_wr_count <= r_wr_count + 16'd1;
          end
        end
        ST_CLEAR: begin
          if (clr) begin
            r_cnt      <= '0;
            r_wr_count <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Register file: the clear engine has priority; writeback is blocked
  // while busy anyway because wb_ready is low.
  always_ff @(posedge sys_clk) begin
    if (r_busy && !sys_rst) begin
      r_regs[r_cnt] <= '0;
    end else if (w_accept && !sys_rst) begin
      r_regs[wb_addr] <= w_merged;
    end
  end

  // Registered read ports with same-cycle write bypass.
  always_ff @(posedge sys_clk) begin
    if (w_zero_rd) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rd0 <= (w_accept && (wb_addr == r0_addr)) ? w_merged : r_regs[r0_addr];
      r_rd1 <= (w_accept && (wb_addr == r1_addr)) ? w_merged : r_regs[r1_addr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mpu_wb.sv
// ============================================================================
// tb_mpu_wb
// ----------------------------------------------------------------------------
// Self-checking bench for mpu_wb: table of lane merges with hand-computed
// results, plus sequences for reset/clear timing, bypass, clr collision and
// the saturating writeback counter. Read expectations flow through a queue.
//
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mpu_wb;

  logic        sys_clk;
  logic        sys_rst;
  logic        clr;
  logic        busy;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [1:0]  wb_size;
  logic [2:0]  wb_sel;
  logic [63:0] wb_data;
  logic [2:0]  r0_addr;
  logic [63:0] r0_data;
  logic [2:0]  r1_addr;
  logic [63:0] r1_data;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q [$];

  typedef struct {
    logic [2:0]  addr;
    logic [1:0]  size;
    logic [2:0]  sel;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [10];

  mpu_wb #(.NREG(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clr      (clr),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_size  (wb_size),
    .wb_sel   (wb_sel),
    .wb_data  (wb_data),
    .r0_addr  (r0_addr),
    .r0_data  (r0_data),
    .r1_addr  (r1_addr),
    .r1_data  (r1_data),
    .wr_count (wr_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single accepted write, bounded wait for wb_ready.
  task automatic do_write(input logic [2:0] a, input logic [1:0] s,
                          input logic [2:0] l, input logic [63:0] d);
    int n;
    wb_addr  = a;
    wb_size  = s;
    wb_sel   = l;
    wb_data  = d;
    wb_valid = 1'b1;
    #1;
    n = 0;
    while (!wb_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("write_ready_timeout", 64'(wb_ready), 64'd1);
    tick();
    wb_valid = 1'b0;
  endtask

  // Issue a read on both ports; expectation queued now, compared on output.
  task automatic check_read(input string name, input logic [2:0] a, input logic [63:0] exp);
    logic [63:0] e;
    r0_addr = a;
    r1_addr = a;
    sb_q.push_back(exp);
    tick();
    e = sb_q.pop_front();
    check({name, "_r0"}, r0_data, e);
    check({name, "_r1"}, r1_data, e);
  endtask

  task automatic count_busy(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 30) begin
      if (wb_ready) check({name, "_ready_while_busy"}, 64'(wb_ready), 64'd0);
      tick();
      n++;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    vecs[0] = '{3'd2, 2'd0, 3'd3, 64'h00000000AB000000, 64'h00000000AB000000};
    vecs[1] = '{3'd2, 2'd0, 3'd0, 64'hFFFFFFFFFFFFFF11, 64'h00000000AB000011};
    vecs[2] = '{3'd1, 2'd3, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{3'd1, 2'd2, 3'd2, 64'h0000000012345678, 64'hFFFFFFFF12345678};
    vecs[4] = '{3'd1, 2'd3, 3'd5, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[5] = '{3'd3, 2'd1, 3'd3, 64'h1234000000000000, 64'h1234000000000000};
    vecs[6] = '{3'd3, 2'd0, 3'd7, 64'hCDFFFFFFFFFFFFFF, 64'hCD34000000000000};
    vecs[7] = '{3'd5, 2'd2, 3'd1, 64'hDEADBEEFFFFFFFFF, 64'hDEADBEEF00000000};
    vecs[8] = '{3'd5, 2'd1, 3'd2, 64'h0000CAFE11111111, 64'hDEADCAFE00000000};
    vecs[9] = '{3'd6, 2'd2, 3'd3, 64'h8765432100000000, 64'h8765432100000000};

    sys_rst  = 1'b1;
    clr      = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_size  = '0;
    wb_sel   = '0;
    wb_data  = '0;
    r0_addr  = '0;
    r1_addr  = '0;

    // Reset then idle
    tick();
    sys_rst = 1'b0;
    check("rst_busy",     64'(busy),     64'd1);
    check("rst_ready",    64'(wb_ready), 64'd0);
    check("rst_r0",       r0_data,       64'd0);
    check("rst_r1",       r1_data,       64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    count_busy("rst", 8);
    check("idle_busy",  64'(busy),     64'd0);
    check("idle_ready", 64'(wb_ready), 64'd1);
    for (int i = 0; i < 8; i++) check_read($sformatf("zero_reg%0d", i), 3'(i), 64'd0);

    // Lane merge table
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].addr, vecs[i].size, vecs[i].sel, vecs[i].data);
      check_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("count_after_table", 64'(wr_count), 64'd10);

    // Same-cycle bypass on both ports
    wb_addr = 3'd4; wb_size = 2'd1; wb_sel = 3'd1; wb_data = 64'h00000000BEEF0000;
    wb_valid = 1'b1;
    r0_addr = 3'd4; r1_addr = 3'd4;
    sb_q.push_back(64'h00000000BEEF0000);
    tick();
    wb_valid = 1'b0;
    begin
      logic [63:0] e;
      e = sb_q.pop_front();
      check("bypass_r0", r0_data, e);
      check("bypass_r1", r1_data, e);
    end

    // Back-to-back merges into the same register
    wb_addr = 3'd4; wb_size = 2'd0; wb_sel = 3'd0; wb_data = 64'hFFFFFFFFFFFFFF11;
    wb_valid = 1'b1;
    tick();
    wb_sel = 3'd1; wb_data = 64'hFFFFFFFFFFFF22FF;
    tick();
    wb_valid = 1'b0;
    check_read("b2b", 3'd4, 64'h00000000BEEF2211);
    check("count_after_b2b", 64'(wr_count), 64'd13);

    // clr collides with a write: clr wins
    clr = 1'b1; wb_valid = 1'b1;
    wb_addr = 3'd0; wb_size = 2'd3; wb_sel = 3'd0; wb_data = 64'hFFFFFFFFFFFFFFFF;
    #1;
    check("clr_ready_low", 64'(wb_ready), 64'd0);
    tick();
    clr = 1'b0;
    check("clr_busy",     64'(busy),     64'd1);
    check("clr_wr_count", 64'(wr_count), 64'd0);
    // hold the write pending through the clear; restart on the 4th cycle
    tick(); tick(); tick();
    wb_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    count_busy("restart", 8);
    check("restart_wr_count", 64'(wr_count), 64'd0);
    check_read("clr_reg0", 3'd0, 64'd0);
    check_read("clr_reg2", 3'd2, 64'd0);

    // Counter: 5 back-to-back writes
    wb_addr = 3'd7; wb_size = 2'd3; wb_sel = 3'd0;
    wb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wb_data = 64'(i + 100);
      tick();
    end
    wb_valid = 1'b0;
    check("count5", 64'(wr_count), 64'd5);
    check_read("count5_reg7", 3'd7, 64'd104);

    // Drive count up to 16'hfffe, then three more to hit saturation
    wb_valid = 1'b1;
    for (int i = 5; i < 65534; i++) tick();
    wb_valid = 1'b0;
    check("count_fffe", 64'(wr_count), 64'h0000_0000_0000_fffe);
    wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    wb_valid = 1'b0;
    check("count_sat", 64'(wr_count), 64'h0000_0000_0000_ffff);
    tick();
    check("count_hold", 64'(wr_count), 64'h0000_0000_0000_ffff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
